mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles per access (legal range 1..7).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-004 SHALL have ports: clock in 1 system clock; reset_n in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: req in 1 access request; addr in 32 byte address; data in 32 write data; byteena in 4 byte lane enables; wren in 1 write (1) / read (0).
REQ-006 SHALL have ports: memWait out 1 busy; q out 32 response data; rvalid out 1 response strobe; fault out 1 access fault.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-009 SHALL accept a request only when req=1 in IDLE (cycle T) and SHALL latch addr, data, byteena and wren at T.
REQ-010 SHALL ignore req while in WAIT or RESP; the requester holds req, and it is re-sampled in the next IDLE.
REQ-011 SHALL drive memWait=1 from T+1 through T+LATENCY inclusive, and 0 otherwise.
REQ-012 SHALL pulse rvalid=1 for exactly one cycle at T+LATENCY+1 (RESP), then return to IDLE.
REQ-013 SHALL compute word index = (addr - BASE_ADDR) >> 2, using 32-bit unsigned wrap-around subtraction.
REQ-014 SHALL on read present the stored word on q with rvalid.
REQ-015 SHALL on write update only lanes whose byteena bit is set (bit0 = [7:0]) in the RESP cycle, and present the post-write word on q.
REQ-016 SHALL treat byteena=4'b0000 on a write as a no-op that still responds normally.
REQ-017 SHALL hold q stable between rvalid pulses; q is not defined as zero outside rvalid.
REQ-018 SHALL make the earliest next acceptance the cycle after RESP, giving a minimum request spacing of LATENCY+2 cycles.

Reset
REQ-019 SHALL on reset_n=0 go immediately to IDLE with memWait=0, rvalid=0, fault=0, q=0, and counter=0.
REQ-020 SHALL abort an in-flight access on reset mid-operation: no write is committed and no rvalid is issued.
REQ-021 SHALL NOT clear storage contents on reset.

Configuration
REQ-022 SHALL honor macro MEM_RESPONDER_FAULT_CHECK_EN.
REQ-023 With the macro defined, SHALL flag fault=1 with rvalid when addr[1:0]!=0 or index>=DEPTH_WORDS; the access SHALL not write and q SHALL be 0.
REQ-024 Without the macro, SHALL ignore addr[1:0], take the index modulo DEPTH_WORDS, and tie fault to 0.

Structure
REQ-025 SHALL place the state enum (mem_resp_state_t) and the localparam for the LATENCY limit in a shared package, mem_pkg.
REQ-026 SHALL isolate storage in one sub-module, mem_resp_array: synchronous byte-enabled write, registered read.

Verification
REQ-027 With LATENCY=2, write addr=32'h10, data=32'hDEADBEEF, byteena=4'hF at T -> memWait high at T+1..T+2, rvalid at T+3, q=32'hDEADBEEF.
REQ-028 Write 32'h000000AA with byteena=4'b0001 to 32'h10, then read 32'h10 -> q=32'hDEADBEAA.
REQ-029 Pulse req during WAIT with a different addr -> ignored; exactly one rvalid per accepted request.
REQ-030 Assert reset_n=0 at T+1 of a write to 32'h20 (old value 0) -> no rvalid; a read of 32'h20 after reset returns 0.
REQ-031 With the macro defined, read addr=32'h13 or addr=BASE_ADDR+4*DEPTH_WORDS -> rvalid with fault=1, q=0, and no state change.
REQ-032 Without the macro, write to 4*DEPTH_WORDS+8 -> the read of addr 8 returns that value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared state type, latency limits and byte-merge helper for mem_responder.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_resp_state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 7;
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  be);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[b*8 +: 8] = be[b] ? newWord[b*8 +: 8] : oldWord[b*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: byte-enabled synchronous write, registered read.
module mem_resp_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_wIndex,
  input  logic [31:0]   i_wData,
  input  logic [AW-1:0] i_rIndex,
  output logic [31:0]   o_rData
);

  // No reset: contents survive reset_n by design.
  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_wIndex][b*8 +: 8] <= i_wData[b*8 +: 8];
        end
      end
    end
    o_rData <= r_mem[i_rIndex];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder (IDLE -> WAIT x LATENCY -> RESP).
// Optional address checking is enabled by defining MEM_RESPONDER_FAULT_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [3:0]  byteena,
  input  logic        wren,
  output logic        memWait,
  output logic [31:0] q,
  output logic        rvalid,
  output logic        fault
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                       (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  mem_resp_state_t r_state, w_nextState;

  logic [CNT_W-1:0] r_count;
  logic [AW-1:0]    r_index, w_index, w_rIndex;
  logic [31:0]      r_data, r_q, w_rData;
  logic [3:0]       r_be;
  logic             r_wren, r_fault;
  logic             w_accept, w_waitDone, w_fault, w_we;

  assign w_index    = AW'((addr - BASE_ADDR) >> 2);
  assign w_accept   = (r_state == ST_IDLE) && req;
  assign w_waitDone = (r_count == CNT_W'(LAT - 1));

`ifdef MEM_RESPONDER_FAULT_CHECK_EN
  assign w_fault = (addr[1:0] != 2'b00) ||
                   (((addr - BASE_ADDR) >> 2) >= 32'(DEPTH_WORDS));
`else
  assign w_fault = 1'b0;
`endif

  // While idle the array reads the incoming address so data is ready one cycle after acceptance.
  assign w_rIndex = (r_state == ST_IDLE) ? w_index : r_index;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (req)        w_nextState = ST_WAIT;
      ST_WAIT: if (w_waitDone) w_nextState = ST_RESP;
      ST_RESP:                 w_nextState = ST_IDLE;
      default:                 w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    memWait = (r_state == ST_WAIT);
    rvalid  = (r_state == ST_RESP);
    fault   = (r_state == ST_RESP) && r_fault;
    w_we    = (r_state == ST_RESP) && r_wren && !r_fault;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_index <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_wren  <= 1'b0;
      r_fault <= 1'b0;
      r_q     <= '0;
    end else begin
      if (w_accept) begin
        r_count <= '0;
        r_index <= w_index;
        r_data  <= data;
        r_be    <= byteena;
        r_wren  <= wren;
        r_fault <= w_fault;
      end else if (r_state == ST_WAIT) begin
        r_count <= r_count + CNT_W'(1);
        // Response word is captured on entry to RESP and held until the next one.
        if (w_waitDone) begin
          if (r_fault) begin
            r_q <= '0;
          end else if (r_wren) begin
            r_q <= mergeBytes(w_rData, r_data, r_be);
          end else begin
            r_q <= w_rData;
          end
        end
      end
    end
  end

  assign q = r_q;

  mem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clock   (clock),
    .i_we    (w_we),
    .i_be    (r_be),
    .i_wIndex(r_index),
    .i_wData (r_data),
    .i_rIndex(w_rIndex),
    .o_rData (w_rData)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a transaction-level memory model.
// Fault checks are exercised when MEM_RESPONDER_FAULT_CHECK_EN is defined.
module tb_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset_n, req, wren;
  logic [31:0] addr, data, q;
  logic [3:0]  byteena;
  logic        memWait, rvalid, fault;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] lastQ;

  always #5 clock = ~clock;

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .addr   (addr),
    .data   (data),
    .byteena(byteena),
    .wren   (wren),
    .memWait(memWait),
    .q      (q),
    .rvalid (rvalid),
    .fault  (fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic bit isFault(input logic [31:0] a);
`ifdef MEM_RESPONDER_FAULT_CHECK_EN
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || ((off / 4) >= 32'(DEPTH));
`else
    return (a === 32'hx);
`endif
  endfunction

  function automatic int wordIndex(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off / 4) % 32'(DEPTH));
  endfunction

  // Issues one request from an idle DUT (called at a negedge) and checks the whole handshake.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic w, input bit disturb);
    logic [31:0] expQ;
    bit          expF;
    int          idx;
    idx  = wordIndex(a);
    expF = isFault(a);
    if (expF) begin
      expQ = 32'h0;
    end else begin
      expQ = model[idx];
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) expQ[b*8 +: 8] = d[b*8 +: 8];
        model[idx] = expQ;
      end
    end
    req = 1'b1; addr = a; data = d; byteena = be; wren = w;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      if (k == 1) begin
        if (disturb) begin
          addr = a ^ 32'h0000_0040; data = ~d; wren = ~w;
        end else begin
          req = 1'b0;
        end
      end
      checkOutput("memWait_in_wait", 32'(memWait), 32'd1);
      checkOutput("rvalid_in_wait", 32'(rvalid), 32'd0);
    end
    @(negedge clock);
    req = 1'b0;
    checkOutput("rvalid_in_resp", 32'(rvalid), 32'd1);
    checkOutput("memWait_in_resp", 32'(memWait), 32'd0);
    checkOutput("q_in_resp", q, expQ);
    checkOutput("fault_in_resp", 32'(fault), 32'(expF));
    lastQ = q;
    @(negedge clock);
    checkOutput("rvalid_after_resp", 32'(rvalid), 32'd0);
    checkOutput("q_hold", q, expQ);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          sel;
    reset_n = 1'b1; req = 1'b0; wren = 1'b0; addr = '0; data = '0; byteena = '0;
    lastQ = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_memWait", 32'(memWait), 32'd0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    checkOutput("reset_q", q, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Storage is not reset, so establish known contents first.
    for (int i = 0; i < DEPTH; i++) applyStimulus(BASE + 32'(4 * i), 32'h0, 4'hF, 1'b1, 1'b0);

    applyStimulus(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    checkOutput("full_write_q", lastQ, 32'hDEADBEEF);
    applyStimulus(BASE + 32'h10, 32'h000000AA, 4'b0001, 1'b1, 1'b0);
    checkOutput("lane0_write_q", lastQ, 32'hDEADBEAA);
    applyStimulus(BASE + 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("lane0_readback", lastQ, 32'hDEADBEAA);
    applyStimulus(BASE + 32'h10, 32'h11223344, 4'h0, 1'b1, 1'b0);
    checkOutput("be_zero_write_q", lastQ, 32'hDEADBEAA);

    applyStimulus(BASE + 32'h14, 32'h55667788, 4'b1010, 1'b1, 1'b1);
    for (int k = 0; k < LAT + 3; k++) begin
      checkOutput("no_extra_rvalid", 32'(rvalid), 32'd0);
      @(negedge clock);
    end
    applyStimulus(BASE + 32'h54, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("ignored_addr_untouched", lastQ, 32'h0);

    req = 1'b1; addr = BASE + 32'h20; data = 32'h12345678; byteena = 4'hF; wren = 1'b1;
    @(negedge clock);
    req = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_memWait", 32'(memWait), 32'd0);
    checkOutput("abort_rvalid", 32'(rvalid), 32'd0);
    checkOutput("abort_q", q, 32'h0);
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clock);
      checkOutput("abort_no_rvalid", 32'(rvalid), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(BASE + 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("abort_no_commit", lastQ, 32'h0);

`ifdef MEM_RESPONDER_FAULT_CHECK_EN
    applyStimulus(BASE + 32'h13, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("misaligned_fault_q", lastQ, 32'h0);
    applyStimulus(BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    checkOutput("range_fault_q", lastQ, 32'h0);
    applyStimulus(BASE, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("range_fault_no_write", lastQ, 32'h0);
`else
    applyStimulus(BASE + 32'(4 * DEPTH) + 32'h8, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
    applyStimulus(BASE + 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("wrap_readback", lastQ, 32'hCAFEF00D);
    applyStimulus(BASE + 32'h33, 32'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("low_bits_ignored", lastQ, model[12]);
`endif

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = BASE + 32'($urandom_range(0, 8 * DEPTH - 1));
      else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (sel == 8) a = $urandom;
      else               a = BASE - 32'($urandom_range(1, 64));
      applyStimulus(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
